// File: rtl/cpu_pkg.sv
// Shared definitions for the multi-cycle CPU: opcodes, ALU function codes and FSM state encodings.
package cpu_pkg;

  localparam logic [3:0] OP_RTYPE = 4'b0000;
  localparam logic [3:0] OP_LB    = 4'b0010;
  localparam logic [3:0] OP_SB    = 4'b0100;
  localparam logic [3:0] OP_ADDI  = 4'b0101;
  localparam logic [3:0] OP_ANDI  = 4'b0110;
  localparam logic [3:0] OP_ORI   = 4'b0111;
  localparam logic [3:0] OP_BEQ   = 4'b1000;
  localparam logic [3:0] OP_BNE   = 4'b1001;
  localparam logic [3:0] OP_JMP   = 4'b1111;

  localparam logic [2:0] FS_ADD = 3'd0;
  localparam logic [2:0] FS_SUB = 3'd1;
  localparam logic [2:0] FS_SLL = 3'd2;
  localparam logic [2:0] FS_SRL = 3'd3;
  localparam logic [2:0] FS_SRA = 3'd4;
  localparam logic [2:0] FS_AND = 3'd5;
  localparam logic [2:0] FS_OR  = 3'd6;
  localparam logic [2:0] FS_XOR = 3'd7;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  function automatic logic writes_rd(input logic [3:0] op);
    return (op == OP_RTYPE) || (op == OP_LB) || (op == OP_ADDI) ||
           (op == OP_ANDI) || (op == OP_ORI);
  endfunction

endpackage

// File: rtl/cpu_mc_core_regfile.sv
// 8-entry register file: two asynchronous read ports, one synchronous write port.
module regfile_p #(
  parameter int DW      = 8,
  parameter bit R0_ZERO = 1'b1
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          we_i,
  input  logic [2:0]    wa_i,
  input  logic [DW-1:0] wd_i,
  input  logic [2:0]    ra_a_i,
  input  logic [2:0]    ra_b_i,
  output logic [DW-1:0] rd_a_o,
  output logic [DW-1:0] rd_b_o
);

  logic [DW-1:0] regs_q [8];

  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < 8; i++) regs_q[i] <= '0;
    end else if (we_i && !(R0_ZERO && (wa_i == 3'd0))) begin
      regs_q[wa_i] <= wd_i;
    end
  end

  assign rd_a_o = (R0_ZERO && (ra_a_i == 3'd0)) ? '0 : regs_q[ra_a_i];
  assign rd_b_o = (R0_ZERO && (ra_b_i == 3'd0)) ? '0 : regs_q[ra_b_i];

endmodule

// File: rtl/cpu_mc_core.sv
// Multi-cycle CPU core with req/ack instruction and data ports; AW must be at least 8.
module cpu_mc_core
  import cpu_pkg::*;
#(
  parameter int DW       = 8,
  parameter int AW       = 8,
  parameter int RESET_PC = 0,
  parameter bit R0_ZERO  = 1'b1
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          EN_L,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_ack,
  input  logic [15:0]   imem_rdata,
  output logic          dmem_req,
  output logic          dmem_we,
  output logic [AW-1:0] dmem_addr,
  output logic [DW-1:0] dmem_wdata,
  input  logic          dmem_ack,
  input  logic [DW-1:0] dmem_rdata,
  output logic [AW-1:0] PC,
  output logic [2:0]    state_o
);

  // state    | meaning
  // FETCH    | request instruction at PC, latch IR on ack
  // DECODE   | latch RA/RB register values into A/B
  // EXEC     | latch ALU result / memory address and next PC
  // MEM      | LB/SB data handshake, latch load data on ack
  // WB       | register write-back and PC update

  localparam int SW = $clog2(DW);

  state_t        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d, npc_q, npc_d, npc;
  logic [15:0]   ir_q, ir_d;
  logic [DW-1:0] a_q, a_d, b_q, b_d, res_q, res_d, ld_q, ld_d;
  logic          ifl_q, ifl_d;
  logic          rf_we;
  logic [DW-1:0] rf_a, rf_b, alu_y;

  logic [3:0]    op;
  logic [DW-1:0] imm_dw;
  logic [AW-1:0] off_aw, pc_inc;
  logic [SW-1:0] shamt;

  assign op     = ir_q[15:12];
  assign imm_dw = {{(DW-6){ir_q[5]}}, ir_q[5:0]};
  assign off_aw = {{(AW-7){ir_q[5]}}, ir_q[5:0], 1'b0};
  assign pc_inc = pc_q + AW'(2);
  assign shamt  = b_q[SW-1:0];

  regfile_p #(.DW(DW), .R0_ZERO(R0_ZERO)) u_rf (
    .CLK    (CLK),
    .RESET  (RESET),
    .we_i   (rf_we),
    .wa_i   ((op == OP_RTYPE) ? ir_q[5:3] : ir_q[8:6]),
    .wd_i   ((op == OP_LB) ? ld_q : res_q),
    .ra_a_i (ir_q[11:9]),
    .ra_b_i (ir_q[8:6]),
    .rd_a_o (rf_a),
    .rd_b_o (rf_b)
  );

  // Non-R-type ops reuse the adder for ADDI and the LB/SB address.
  always_comb begin
    alu_y = '0;
    if (op == OP_RTYPE) begin
      unique case (ir_q[2:0])
        FS_ADD: alu_y = a_q + b_q;
        FS_SUB: alu_y = a_q - b_q;
        FS_SLL: alu_y = a_q << shamt;
        FS_SRL: alu_y = a_q >> shamt;
        FS_SRA: alu_y = $signed(a_q) >>> shamt;
        FS_AND: alu_y = a_q & b_q;
        FS_OR:  alu_y = a_q | b_q;
        FS_XOR: alu_y = a_q ^ b_q;
      endcase
    end else begin
      case (op)
        OP_ANDI: alu_y = a_q & imm_dw;
        OP_ORI:  alu_y = a_q | imm_dw;
        default: alu_y = a_q + imm_dw;
      endcase
    end
  end

  always_comb begin
    npc = pc_inc;
    case (op)
      OP_BEQ:  if (a_q == b_q) npc = pc_inc + off_aw;
      OP_BNE:  if (a_q != b_q) npc = pc_inc + off_aw;
      OP_JMP:  npc = AW'({ir_q[11:0], 1'b0});
      default: npc = pc_inc;
    endcase
  end

  // Once a fetch is outstanding EN_L no longer matters, so the handshake always completes.
  assign imem_req   = (state_q == S_FETCH) && (ifl_q || !EN_L);
  assign imem_addr  = pc_q;
  assign dmem_req   = (state_q == S_MEM);
  assign dmem_we    = dmem_req && (op == OP_SB);
  assign dmem_addr  = AW'(res_q);
  assign dmem_wdata = b_q;
  assign PC         = pc_q;
  assign state_o    = state_q;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    npc_d   = npc_q;
    ir_d    = ir_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    ld_d    = ld_q;
    ifl_d   = ifl_q;
    rf_we   = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        if (imem_req) begin
          ifl_d = !imem_ack;
          if (imem_ack) begin
            ir_d    = imem_rdata;
            state_d = S_DECODE;
          end
        end
      end
      S_DECODE: begin
        a_d     = rf_a;
        b_d     = rf_b;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        res_d   = alu_y;
        npc_d   = npc;
        state_d = ((op == OP_LB) || (op == OP_SB)) ? S_MEM : S_WB;
      end
      S_MEM: begin
        if (dmem_ack) begin
          ld_d    = dmem_rdata;
          state_d = S_WB;
        end
      end
      S_WB: begin
        rf_we   = writes_rd(op);
        pc_d    = npc_q;
        state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= S_FETCH;
      pc_q    <= AW'(RESET_PC);
      npc_q   <= '0;
      ir_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      ld_q    <= '0;
      ifl_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      npc_q   <= npc_d;
      ir_q    <= ir_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      ld_q    <= ld_d;
      ifl_q   <= ifl_d;
    end
  end

endmodule

// File: tb/tb_cpu_mc_core.sv
// Scoreboard bench for cpu_mc_core: default build, R0_ZERO=0 build and DW=16 build.
module tb_cpu_mc_core;
  import cpu_pkg::*;

  logic CLK = 1'b0, RESET = 1'b1, en_l = 1'b1, en_l_x = 1'b1, stray = 1'b0;
  always #5 CLK = ~CLK;

  int ncmp = 0, nbad = 0;
  int iwait = 0, dwait = 0, icnt = 0, dcnt = 0;

  logic [15:0] rom [128];
  logic [15:0] zrom [128];
  logic [15:0] wrom [128];
  logic [7:0]  dram [256];

  logic [15:0] sq[$], eq[$], zq[$], ezq[$];
  logic [23:0] wq[$], ewq[$];
  logic [7:0]  fq[$], efq[$];

  // default build
  logic imem_req, imem_ack, dmem_req, dmem_we, dmem_ack;
  logic [7:0] imem_addr, dmem_addr, dmem_wdata, dmem_rdata, pc;
  logic [15:0] imem_rdata;
  logic [2:0] st;

  cpu_mc_core u0 (
    .CLK(CLK), .RESET(RESET), .EN_L(en_l),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .PC(pc), .state_o(st));

  assign imem_ack   = imem_req && (icnt >= iwait);
  assign imem_rdata = rom[imem_addr[7:1]];
  assign dmem_ack   = (dmem_req && (dcnt >= dwait)) || stray;
  assign dmem_rdata = dram[dmem_addr];

  always @(posedge CLK) begin
    icnt <= (imem_req && !imem_ack) ? icnt + 1 : 0;
    dcnt <= (dmem_req && !dmem_ack) ? dcnt + 1 : 0;
    if (!RESET && imem_req && imem_ack) fq.push_back(imem_addr);
    if (!RESET && dmem_req && dmem_ack && dmem_we) begin
      dram[dmem_addr] <= dmem_wdata;
      sq.push_back({dmem_addr, dmem_wdata});
    end
  end

  // R0 as ordinary register
  logic z_imem_req, z_dmem_req, z_dmem_we;
  logic [7:0] z_imem_addr, z_dmem_addr, z_dmem_wdata, z_pc;
  logic [2:0] z_st;
  cpu_mc_core #(.R0_ZERO(1'b0)) u1 (
    .CLK(CLK), .RESET(RESET), .EN_L(en_l_x),
    .imem_req(z_imem_req), .imem_addr(z_imem_addr), .imem_ack(z_imem_req),
    .imem_rdata(zrom[z_imem_addr[7:1]]),
    .dmem_req(z_dmem_req), .dmem_we(z_dmem_we), .dmem_addr(z_dmem_addr), .dmem_wdata(z_dmem_wdata),
    .dmem_ack(z_dmem_req), .dmem_rdata(8'h00), .PC(z_pc), .state_o(z_st));

  // 16-bit datapath
  logic w_imem_req, w_dmem_req, w_dmem_we;
  logic [7:0] w_imem_addr, w_dmem_addr, w_pc;
  logic [15:0] w_dmem_wdata;
  logic [2:0] w_st;
  cpu_mc_core #(.DW(16)) u2 (
    .CLK(CLK), .RESET(RESET), .EN_L(en_l_x),
    .imem_req(w_imem_req), .imem_addr(w_imem_addr), .imem_ack(w_imem_req),
    .imem_rdata(wrom[w_imem_addr[7:1]]),
    .dmem_req(w_dmem_req), .dmem_we(w_dmem_we), .dmem_addr(w_dmem_addr), .dmem_wdata(w_dmem_wdata),
    .dmem_ack(w_dmem_req), .dmem_rdata(16'h8000), .PC(w_pc), .state_o(w_st));

  always @(posedge CLK) begin
    if (!RESET && z_dmem_req && z_dmem_we) zq.push_back({z_dmem_addr, z_dmem_wdata});
    if (!RESET && w_dmem_req && w_dmem_we) wq.push_back({w_dmem_addr, w_dmem_wdata});
  end

  function automatic logic [15:0] enc_i(input logic [3:0] op, input logic [2:0] ra,
                                        input logic [2:0] rb, input logic [5:0] imm);
    return {op, ra, rb, imm};
  endfunction

  function automatic logic [15:0] enc_r(input logic [2:0] ra, input logic [2:0] rb,
                                        input logic [2:0] dr, input logic [2:0] fs);
    return {OP_RTYPE, ra, rb, dr, fs};
  endfunction

  task automatic do_reset();
    @(posedge CLK); #1;
    RESET = 1'b1; en_l = 1'b1; en_l_x = 1'b1; stray = 1'b0;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    for (int i = 0; i < 256; i++) dram[i] = 8'h00;
    sq.delete(); eq.delete(); zq.delete(); ezq.delete();
    wq.delete(); ewq.delete(); fq.delete(); efq.delete();
    RESET = 1'b0;
  endtask

  task automatic clear_roms();
    for (int i = 0; i < 128; i++) begin rom[i] = 16'h0; zrom[i] = 16'h0; wrom[i] = 16'h0; end
  endtask

  task automatic test_reset();
    clear_roms(); iwait = 0; dwait = 0;
    do_reset();
    repeat (5) @(posedge CLK);
    #1;
    ncmp++; if (imem_req !== 1'b0) begin nbad++; $display("FAIL rst_imem_req got %b want 0", imem_req); end
    ncmp++; if (pc !== 8'h00) begin nbad++; $display("FAIL rst_pc got %h want 00", pc); end
    ncmp++; if (st !== 3'd0) begin nbad++; $display("FAIL rst_state got %0d want 0", st); end
    ncmp++; if ({dmem_req, dmem_we} !== 2'b00) begin nbad++; $display("FAIL rst_dmem got %b want 00", {dmem_req, dmem_we}); end
    en_l = 1'b0; #1;
    ncmp++; if (imem_req !== 1'b1) begin nbad++; $display("FAIL run_imem_req got %b want 1", imem_req); end
    ncmp++; if (imem_addr !== 8'h00) begin nbad++; $display("FAIL run_imem_addr got %h want 00", imem_addr); end
  endtask

  task automatic test_alu();
    logic [15:0] got, exp;
    clear_roms(); iwait = 0; dwait = 0;
    rom[0] = enc_i(OP_ADDI, 3'd0, 3'd1, 6'd5);
    rom[1] = enc_r(3'd1, 3'd1, 3'd2, FS_ADD);
    rom[2] = enc_i(OP_ADDI, 3'd0, 3'd3, 6'h3F);
    rom[3] = enc_i(OP_SB, 3'd0, 3'd2, 6'd0);
    rom[4] = enc_i(OP_SB, 3'd0, 3'd3, 6'd1);
    rom[5] = {OP_JMP, 12'h005};
    do_reset();
    eq.push_back({8'd0, 8'd10});
    eq.push_back({8'd1, 8'hFF});
    en_l = 1'b0;
    repeat (8) @(posedge CLK);
    #1;
    ncmp++; if (pc !== 8'd4) begin nbad++; $display("FAIL alu_cpi_pc got %h want 04", pc); end
    ncmp++; if (st !== 3'd0) begin nbad++; $display("FAIL alu_cpi_state got %0d want 0", st); end
    for (int k = 0; k < 200 && sq.size() < 2; k++) @(posedge CLK);
    #1;
    ncmp++; if (sq.size() < 2) begin nbad++; $display("FAIL alu_store_count got %0d want 2", sq.size()); end
    while (eq.size() > 0 && sq.size() > 0) begin
      exp = eq.pop_front(); got = sq.pop_front();
      ncmp++; if (got !== exp) begin nbad++; $display("FAIL alu_store got %h want %h", got, exp); end
    end
  endtask

  task automatic test_mem_wait();
    logic [15:0] got, exp;
    logic [7:0] a0, w0;
    logic stable;
    int hi;
    clear_roms(); iwait = 0; dwait = 3;
    rom[0] = enc_i(OP_ADDI, 3'd0, 3'd1, 6'd5);
    rom[1] = enc_i(OP_SB, 3'd0, 3'd1, 6'd3);
    rom[2] = enc_i(OP_LB, 3'd0, 3'd4, 6'd3);
    rom[3] = enc_i(OP_SB, 3'd0, 3'd4, 6'd4);
    rom[4] = {OP_JMP, 12'h004};
    do_reset();
    eq.push_back({8'd3, 8'd5});
    eq.push_back({8'd4, 8'd5});
    en_l = 1'b0;
    for (int k = 0; k < 100 && !dmem_req; k++) begin @(posedge CLK); #1; end
    ncmp++; if (dmem_req !== 1'b1) begin nbad++; $display("FAIL mem_req_timeout got %b want 1", dmem_req); end
    a0 = dmem_addr; w0 = dmem_wdata; stable = 1'b1; hi = 0;
    while (dmem_req && hi < 20) begin
      if (dmem_addr !== a0 || dmem_wdata !== w0 || dmem_we !== 1'b1) stable = 1'b0;
      hi++;
      @(posedge CLK); #1;
    end
    ncmp++; if (hi !== 4) begin nbad++; $display("FAIL mem_req_cycles got %0d want 4", hi); end
    ncmp++; if (a0 !== 8'd3) begin nbad++; $display("FAIL mem_addr got %h want 03", a0); end
    ncmp++; if (w0 !== 8'd5) begin nbad++; $display("FAIL mem_wdata got %h want 05", w0); end
    ncmp++; if (stable !== 1'b1) begin nbad++; $display("FAIL mem_stable got %b want 1", stable); end
    for (int k = 0; k < 300 && sq.size() < 2; k++) @(posedge CLK);
    #1;
    ncmp++; if (sq.size() < 2) begin nbad++; $display("FAIL mem_store_count got %0d want 2", sq.size()); end
    while (eq.size() > 0 && sq.size() > 0) begin
      exp = eq.pop_front(); got = sq.pop_front();
      ncmp++; if (got !== exp) begin nbad++; $display("FAIL mem_store got %h want %h", got, exp); end
    end
  endtask

  task automatic test_branch();
    logic [7:0] got, exp;
    logic [7:0] seq [10];
    clear_roms(); iwait = 1; dwait = 0;
    rom[0] = enc_i(OP_ADDI, 3'd0, 3'd1, 6'd5);
    rom[1] = {OP_JMP, 12'h003};
    rom[2] = {OP_JMP, 12'h004};
    rom[3] = enc_i(OP_BEQ, 3'd1, 3'd1, 6'h3E);
    rom[4] = enc_i(OP_BNE, 3'd1, 3'd0, 6'd1);
    rom[6] = enc_i(OP_BNE, 3'd1, 3'd1, 6'h3D);
    rom[7] = {OP_JMP, 12'h07F};
    seq = '{8'd0, 8'd2, 8'd6, 8'd4, 8'd8, 8'd12, 8'd14, 8'hFE, 8'd0, 8'd2};
    do_reset();
    for (int i = 0; i < 10; i++) efq.push_back(seq[i]);
    en_l = 1'b0;
    for (int k = 0; k < 400 && fq.size() < 10; k++) @(posedge CLK);
    #1;
    ncmp++; if (fq.size() < 10) begin nbad++; $display("FAIL br_fetch_count got %0d want 10", fq.size()); end
    while (efq.size() > 0 && fq.size() > 0) begin
      exp = efq.pop_front(); got = fq.pop_front();
      ncmp++; if (got !== exp) begin nbad++; $display("FAIL br_fetch_pc got %h want %h", got, exp); end
    end
  endtask

  task automatic test_r0();
    logic [15:0] got, exp;
    clear_roms(); iwait = 0; dwait = 0;
    rom[0] = enc_i(OP_ADDI, 3'd0, 3'd0, 6'd7);
    rom[1] = enc_i(OP_SB, 3'd0, 3'd0, 6'd2);
    rom[2] = {OP_JMP, 12'h002};
    for (int i = 0; i < 3; i++) zrom[i] = rom[i];
    do_reset();
    eq.push_back({8'd2, 8'd0});
    ezq.push_back({8'd9, 8'd7});
    en_l = 1'b0; en_l_x = 1'b0;
    for (int k = 0; k < 200 && (sq.size() < 1 || zq.size() < 1); k++) @(posedge CLK);
    #1;
    ncmp++; if (sq.size() < 1 || zq.size() < 1) begin nbad++; $display("FAIL r0_store_count got %0d/%0d want 1/1", sq.size(), zq.size()); end
    if (eq.size() > 0 && sq.size() > 0) begin
      exp = eq.pop_front(); got = sq.pop_front();
      ncmp++; if (got !== exp) begin nbad++; $display("FAIL r0_zero_store got %h want %h", got, exp); end
    end
    if (ezq.size() > 0 && zq.size() > 0) begin
      exp = ezq.pop_front(); got = zq.pop_front();
      ncmp++; if (got !== exp) begin nbad++; $display("FAIL r0_plain_store got %h want %h", got, exp); end
    end
  endtask

  task automatic test_wide_shift();
    logic [23:0] got, exp;
    clear_roms(); iwait = 0; dwait = 0;
    wrom[0] = enc_i(OP_LB, 3'd0, 3'd1, 6'd0);
    wrom[1] = enc_i(OP_ADDI, 3'd0, 3'd2, 6'd4);
    wrom[2] = enc_r(3'd1, 3'd2, 3'd3, FS_SRA);
    wrom[3] = enc_r(3'd1, 3'd2, 3'd4, FS_SRL);
    wrom[4] = enc_i(OP_SB, 3'd0, 3'd3, 6'd1);
    wrom[5] = enc_i(OP_SB, 3'd0, 3'd4, 6'd2);
    wrom[6] = {OP_JMP, 12'h006};
    do_reset();
    ewq.push_back({8'd1, 16'hF800});
    ewq.push_back({8'd2, 16'h0800});
    en_l_x = 1'b0;
    for (int k = 0; k < 300 && wq.size() < 2; k++) @(posedge CLK);
    #1;
    ncmp++; if (wq.size() < 2) begin nbad++; $display("FAIL wide_store_count got %0d want 2", wq.size()); end
    while (ewq.size() > 0 && wq.size() > 0) begin
      exp = ewq.pop_front(); got = wq.pop_front();
      ncmp++; if (got !== exp) begin nbad++; $display("FAIL wide_shift_store got %h want %h", got, exp); end
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] got, exp;
    clear_roms(); iwait = 0; dwait = 50;
    rom[0] = enc_i(OP_ADDI, 3'd0, 3'd1, 6'd5);
    rom[1] = enc_i(OP_SB, 3'd0, 3'd1, 6'd3);
    rom[2] = {OP_JMP, 12'h002};
    do_reset();
    dram[0] = 8'hA5;
    en_l = 1'b0;
    for (int k = 0; k < 100 && !dmem_req; k++) begin @(posedge CLK); #1; end
    ncmp++; if (dmem_req !== 1'b1) begin nbad++; $display("FAIL mid_req_timeout got %b want 1", dmem_req); end
    RESET = 1'b1; en_l = 1'b1;
    @(posedge CLK); #1;
    ncmp++; if (dmem_req !== 1'b0) begin nbad++; $display("FAIL mid_dmem_req got %b want 0", dmem_req); end
    ncmp++; if (st !== 3'd0) begin nbad++; $display("FAIL mid_state got %0d want 0", st); end
    ncmp++; if (pc !== 8'h00) begin nbad++; $display("FAIL mid_pc got %h want 00", pc); end
    RESET = 1'b0; stray = 1'b1; dwait = 0;
    @(posedge CLK); #1;
    stray = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    ncmp++; if (st !== 3'd0) begin nbad++; $display("FAIL mid_stray_state got %0d want 0", st); end
    ncmp++; if (sq.size() !== 0) begin nbad++; $display("FAIL mid_stray_store got %0d want 0", sq.size()); end
    rom[0] = enc_i(OP_SB, 3'd0, 3'd1, 6'd5);
    rom[1] = {OP_JMP, 12'h001};
    eq.push_back({8'd5, 8'd0});
    en_l = 1'b0;
    for (int k = 0; k < 100 && sq.size() < 1; k++) @(posedge CLK);
    #1;
    ncmp++; if (sq.size() < 1) begin nbad++; $display("FAIL mid_store_count got %0d want 1", sq.size()); end
    if (eq.size() > 0 && sq.size() > 0) begin
      exp = eq.pop_front(); got = sq.pop_front();
      ncmp++; if (got !== exp) begin nbad++; $display("FAIL mid_r1_cleared got %h want %h", got, exp); end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_roms();
    for (int i = 0; i < 256; i++) dram[i] = 8'h00;
    test_reset();
    test_alu();
    test_mem_wait();
    test_branch();
    test_r0();
    test_wide_shift();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end

endmodule
